// File: rtl/tt_pkg.sv
// rtl/tt_pkg.sv - shared types and constants for the truth-table sweep evaluator
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic MODE_SOP = 1'b0;
    localparam logic MODE_POS = 1'b1;

    function automatic int depth_of(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/tt_mask_sreg.sv
// rtl/tt_mask_sreg.sv - serially loaded term mask with indexed read port
module tt_mask_sreg
    import tt_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = depth_of(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         shift_en,
    input  logic         shift_bit,
    input  logic [N-1:0] rd_idx,
    output logic         rd_bit
);

    logic [DEPTH-1:0] mask_q;
    logic [DEPTH-1:0] mask_d;

    // New bits enter at index 0, so the first bit written ends up at DEPTH-1.
    always_comb begin
        mask_d = mask_q;
        if (shift_en) begin
            mask_d = {mask_q[DEPTH-2:0], shift_bit};
        end
        rd_bit = mask_q[rd_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

endmodule

// File: rtl/tt_sweep_eval.sv
// rtl/tt_sweep_eval.sv - programmable N-input SoP/PoS evaluator streaming its truth table
module tt_sweep_eval
    import tt_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = depth_of(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic             cfg_bit,
    input  logic             mode,
    input  logic             start,
    input  logic             s_ready,
    output logic             busy,
    output logic             s_valid,
    output logic [N-1:0]     idx,
    output logic             s_out,
    output logic             done,
    output logic [DEPTH-1:0] result,
    output logic [N:0]       ones_count
);

    localparam logic [N-1:0] LAST_IDX = N'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [N-1:0]     idx_q, idx_d;
    logic [DEPTH-1:0] result_q, result_d;
    logic [N:0]       ones_q, ones_d;
    logic             mode_q, mode_d;
    logic             shift_en;
    logic             mask_bit;

    tt_mask_sreg #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_mask (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_en  (shift_en),
        .shift_bit (cfg_bit),
        .rd_idx    (idx_q),
        .rd_bit    (mask_bit)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        result_d = result_q;
        ones_d   = ones_q;
        mode_d   = mode_q;
        busy     = 1'b0;
        s_valid  = 1'b0;
        s_out    = 1'b0;
        done     = 1'b0;
        shift_en = 1'b0;

        case (state_q)
            IDLE: begin
                // The mask only moves here, so it is frozen for a whole sweep.
                shift_en = cfg_we;
                if (start) begin
                    state_d  = SWEEP;
                    mode_d   = mode;
                    idx_d    = '0;
                    result_d = '0;
                    ones_d   = '0;
                end
            end
            SWEEP: begin
                busy    = 1'b1;
                s_valid = 1'b1;
                s_out   = mask_bit ^ (mode_q == MODE_POS);
                if (s_ready) begin
                    result_d[idx_q] = s_out;
                    ones_d          = ones_q + (N+1)'(s_out);
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            result_q <= '0;
            ones_q   <= '0;
            mode_q   <= MODE_SOP;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            ones_q   <= ones_d;
            mode_q   <= mode_d;
        end
    end

    assign idx        = idx_q;
    assign result     = result_q;
    assign ones_count = ones_q;

endmodule

// File: doc/tt_sweep_eval.md
Name: tt_sweep_eval

Overview:
Parametrised, programmable N-input boolean function evaluator; generalises fixed 4-input SoP/PoS gate blocks.
- Term mask is loaded serially and interpreted at run time as a minterm list (SoP) or a maxterm list (PoS).
- On request, a counter sweeps all 2^N input combinations and streams one result per accepted beat under a valid/ready handshake, accumulating the full truth table and a ones count.
- Self-checking truth-table engine for the Guia exercises: replaces hand-written #1 stimulus lists.

Parameters:
N, 4, number of function inputs (1..8)
DEPTH, 2**N, truth-table rows; derived, do not override

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
cfg_we  input  1  shift enable for term mask; ignored unless IDLE
cfg_bit  input  1  serial mask bit; first bit shifted lands at index DEPTH-1 after DEPTH writes
mode  input  1  0 = SoP (mask bit set => S=1), 1 = PoS (mask bit set => S=0); sampled at start
start  input  1  begin sweep; honoured only in IDLE
s_ready  input  1  consumer accepts current beat
busy  output  1  high in SWEEP
s_valid  output  1  beat valid
idx  output  N  input combination of current beat (bit N-1 = X-equivalent MSB)
s_out  output  1  function value at idx
done  output  1  one-cycle pulse after last beat accepted
result  output  DEPTH  captured truth table, bit k = S(k)
ones_count  output  N+1  number of rows with S=1

Behaviour:
- Reset (async, rst_n=0): state IDLE; mask, idx, result, ones_count = 0; busy, s_valid, done, s_out = 0; latched mode = 0.
- Reset mid-sweep: immediate abort to the above values; no done pulse.
- mask: DEPTH-bit shift register. On cfg_we in IDLE: mask <= {mask[DEPTH-2:0], cfg_bit}. cfg_we in SWEEP/DONE is ignored; mask stays stable for the whole sweep.
- FSM states: IDLE, SWEEP, DONE.
- IDLE -> SWEEP on start:
  - mode latched.
  - idx <= 0; result <= 0; ones_count <= 0.
  - If cfg_we and start are asserted in the same IDLE cycle, the shift happens and the sweep uses the updated mask.
- SWEEP:
  - s_valid = 1; busy = 1.
  - s_out = mask[idx] XOR mode_latched (combinational from registered idx).
  - Beat accepted when s_valid & s_ready:
    - result[idx] <= s_out.
    - ones_count += s_out.
    - If idx == DEPTH-1, go to DONE; otherwise idx <= idx+1.
  - s_ready low: hold idx, s_out and s_valid unchanged; no capture. Stalls are unbounded.
  - start in SWEEP is ignored.
- DONE: done = 1 for exactly one cycle; s_valid = 0; then IDLE. idx returns to 0 on entry to IDLE.
- result and ones_count hold their values in IDLE until the next start.
- Latency: first beat valid 1 cycle after start. A full sweep with s_ready held high takes DEPTH cycles of SWEEP plus 1 DONE cycle.
- Width rules:
  - idx counter is N bits and never wraps; the terminal compare stops it at DEPTH-1.
  - ones_count is N+1 bits and can reach DEPTH without overflow.
- x/z on inputs is not handled; the bench drives known values after reset.

Decomposition:
- Package tt_pkg holds:
  - state enum {IDLE, SWEEP, DONE};
  - the mode constants MODE_SOP = 0 and MODE_POS = 1;
  - a function depth_of(n) = 1 << n.
- One natural sub-module, tt_mask_sreg: DEPTH-bit shift register with load enable and a read mux by idx.
- The FSM, counter and accumulators stay in the top module.

Test Plan:
1. Reset, then shift N=4 mask 0x9097 (terms 0,1,2,4,7,12,15), mode=1, start, s_ready=1 -> beats idx 0..15 with s_out=0 at those terms; result=0x6F68, ones_count=9; done pulses at cycle 17 after start.
2. Same mask, mode=0 -> result=0x9097, ones_count=7; s_out=1 exactly at idx 0,1,2,4,7,12,15.
3. Stall: deassert s_ready for 3 cycles at idx=5 -> idx stays 5, s_valid stays high, result bit 5 captured once; final result unchanged from scenario 1.
4. Assert cfg_we with cfg_bit=1 and start during SWEEP -> mask and sweep unaffected; result identical to the undisturbed run.
5. Pull rst_n low at idx=9 -> busy, s_valid, result, ones_count and mask go to 0 asynchronously; done never pulses; a new load and sweep afterwards runs correctly.
6. N=2 build, mask 0b1000, mode=0 -> 4 beats, result=0x8, ones_count=1, done at cycle 5 after start.
